// File: rtl/alu_pkg.sv
// alu_pkg: ALU function-select codes, status bit indices and sequencer states
package alu_pkg;
  localparam logic [4:0] FS_AND  = 5'b00000;
  localparam logic [4:0] FS_OR   = 5'b00100;
  localparam logic [4:0] FS_ADD  = 5'b01000;
  localparam logic [4:0] FS_XOR  = 5'b01100;
  localparam logic [4:0] FS_SHL  = 5'b10000;
  localparam logic [4:0] FS_SHR  = 5'b10100;
  localparam logic [4:0] FS_ZERO = 5'b11000;
  localparam int ST_Z = 0;
  localparam int ST_N = 1;
  localparam int ST_C = 2;
  localparam int ST_V = 3;
  typedef enum logic [2:0] {S_IDLE, S_ADD, S_SHL, S_SHR, S_DONE} seq_state_e;
endpackage

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: 64x64 shift-add multiplier sequencing an external ALU
module alu_mul_sequencer
  import alu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_a,
  input  logic [63:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic        out_ovf,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  output logic [4:0]  alu_fs,
  output logic        alu_c0,
  input  logic [63:0] alu_f,
  input  logic [3:0]  alu_status
);
  seq_state_e  state_q;
  logic [63:0] mcand_q, mplier_q, acc_q;
  logic        ovf_q, in_ready_q, out_valid_q;
  logic        unused_status;
  assign unused_status = ^{alu_status[ST_V], alu_status[ST_N], alu_status[ST_Z]};
  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = acc_q;
  assign out_ovf    = ovf_q;
  assign alu_c0     = 1'b0;
  // ALU operands and function select decoded from the current step
  always_comb begin
    alu_a  = state_q == S_ADD ? acc_q : state_q == S_SHL ? mcand_q : state_q == S_SHR ? mplier_q : '0;
    alu_b  = state_q == S_ADD ? mcand_q : (state_q == S_SHL || state_q == S_SHR) ? 64'd1 : '0;
    alu_fs = state_q == S_ADD ? FS_ADD : state_q == S_SHL ? FS_SHL : state_q == S_SHR ? FS_SHR : FS_ZERO;
  end
  // Sequencer FSM; overflow tracks adder carries and multiplicand bits shifted out while multiplier bits remain
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          mcand_q     <= in_a;
          mplier_q    <= in_b;
          acc_q       <= '0;
          ovf_q       <= 1'b0;
          in_ready_q  <= 1'b0;
          out_valid_q <= in_b == '0;
          state_q     <= in_b == '0 ? S_DONE : S_ADD;
        end
        S_ADD: begin
          if (mplier_q[0]) begin
            acc_q <= alu_f;
            ovf_q <= ovf_q | alu_status[ST_C];
          end
          state_q <= S_SHL;
        end
        S_SHL: begin
          mcand_q <= alu_f;
          if (mcand_q[63] && |mplier_q[63:1]) ovf_q <= 1'b1;
          state_q <= S_SHR;
        end
        S_SHR: begin
          mplier_q    <= alu_f;
          out_valid_q <= alu_f == '0;
          state_q     <= alu_f == '0 ? S_DONE : S_ADD;
        end
        S_DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end
endmodule
